// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared constants and state encoding for the binary-to-BCD converter
package bin2bcd_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int ACC_DIGITS = 5;
    localparam int BIN_W      = 16;
    localparam int STEPS      = 16;

    localparam logic [4*BCD_DIGITS-1:0] BCD_SAT = 16'h9999;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit corrector: adds 3 to any digit of 5 or more
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 16-bit binary to 4-digit packed BCD, one bit per clock
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIN_W-1:0]        bin,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int ACC_W = 4 * ACC_DIGITS;

    state_t             state;
    logic [3:0]         step;
    logic [BIN_W-1:0]   sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_next;
    logic [BIN_W-1:0]   sr_next;
    logic               ovf_next;

    for (genvar d = 0; d < ACC_DIGITS; d++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (acc[4*d +: 4]),
            .dout (acc_adj[4*d +: 4])
        );
    end

    assign {acc_next, sr_next} = {acc_adj, sr} << 1;
    assign ovf_next            = (acc_next[ACC_W-1 -: 4] != 4'd0);
    assign busy                = (state == ST_CONV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            step  <= 4'd0;
            sr    <= '0;
            acc   <= '0;
            done  <= 1'b0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sr    <= bin;
                        acc   <= '0;
                        step  <= 4'd0;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    acc  <= acc_next;
                    sr   <= sr_next;
                    step <= step + 4'd1;
                    // Final shift: publish the result on the same edge that returns to idle.
                    if (step == 4'(STEPS - 1)) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                        ovf   <= ovf_next;
                        bcd   <= (SATURATE && ovf_next) ? BCD_SAT : acc_next[4*BCD_DIGITS-1:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq (saturating and truncating)
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bin;
    logic        start;
    logic        busy_s, done_s, ovf_s;
    logic [15:0] bcd_s;
    logic        busy_t, done_t, ovf_t;
    logic [15:0] bcd_t;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.SATURATE(1'b1)) u_sat (
        .clk   (clk),
        .rst   (rst),
        .bin   (bin),
        .start (start),
        .busy  (busy_s),
        .done  (done_s),
        .bcd   (bcd_s),
        .ovf   (ovf_s)
    );

    bin2bcd_seq #(.SATURATE(1'b0)) u_trunc (
        .clk   (clk),
        .rst   (rst),
        .bin   (bin),
        .start (start),
        .busy  (busy_t),
        .done  (done_t),
        .bcd   (bcd_t),
        .ovf   (ovf_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic run_conv(input string tag, input logic [15:0] v,
                            input logic [15:0] e_sat, input logic [15:0] e_trunc, input logic e_ovf);
        int busy_cnt;
        int bad;
        busy_cnt = 0;
        bad      = 0;
        bin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (busy_s && busy_t) busy_cnt++;
            if (done_s || done_t) bad++;
            tick();
        end
        chk({tag, "_busy_cycles"}, busy_cnt, 16);
        chk({tag, "_early_done"}, bad, 0);
        chk({tag, "_done"}, {done_s, done_t}, 2'b11);
        chk({tag, "_busy_end"}, {busy_s, busy_t}, 2'b00);
        chk({tag, "_bcd_sat"}, bcd_s, e_sat);
        chk({tag, "_bcd_trunc"}, bcd_t, e_trunc);
        chk({tag, "_ovf"}, {ovf_s, ovf_t}, {e_ovf, e_ovf});
        tick();
        chk({tag, "_done_pulse"}, {done_s, done_t}, 2'b00);
        chk({tag, "_bcd_hold"}, bcd_s, e_sat);
    endtask

    initial begin
        int ndone;
        int first_done;
        int bad;

        rst   = 1'b1;
        bin   = 16'd0;
        start = 1'b0;
        tick();
        tick();
        chk("reset_outs", {busy_s, done_s, ovf_s, bcd_s}, 19'h0);
        chk("reset_outs_t", {busy_t, done_t, ovf_t, bcd_t}, 19'h0);
        rst = 1'b0;
        tick();

        run_conv("zero",  16'd0,     16'h0000, 16'h0000, 1'b0);
        run_conv("v1234", 16'd1234,  16'h1234, 16'h1234, 1'b0);
        run_conv("v9999", 16'd9999,  16'h9999, 16'h9999, 1'b0);
        run_conv("v10000", 16'd10000, 16'h9999, 16'h0000, 1'b1);
        run_conv("v65535", 16'd65535, 16'h9999, 16'h5535, 1'b1);

        // Second start and bin changes while converting must be ignored.
        bin   = 16'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                start = 1'b1;
                bin   = 16'd77;
            end
            if (i == 5) begin
                start = 1'b0;
                bin   = 16'd1234;
            end
            if (done_s) ndone++;
            tick();
        end
        chk("ignore_done", done_s, 1'b1);
        chk("ignore_bcd", bcd_s, 16'h0042);
        chk("ignore_ovf", ovf_s, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (done_s) ndone++;
            tick();
        end
        chk("ignore_single_done", ndone, 1);
        chk("ignore_idle", busy_s, 1'b0);

        // Reset in the middle of a conversion.
        bin   = 16'd1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("midrst_busy_before", busy_s, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {busy_s, done_s, ovf_s, bcd_s}, 19'h0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy_s || done_s) bad++;
        end
        chk("midrst_quiet", bad, 0);
        chk("midrst_bcd", bcd_s, 16'h0000);

        // Start held high: one result every 17 cycles.
        bin   = 16'd5;
        start = 1'b1;
        tick();
        ndone      = 0;
        first_done = -1;
        bad        = 0;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (done_s) begin
                ndone++;
                if (first_done < 0) first_done = j;
                if (j != 16 && j != 33 && j != 50) bad++;
                if (bcd_s !== 16'h0005 || ovf_s !== 1'b0) bad++;
            end
        end
        start = 1'b0;
        chk("held_count", ndone, 3);
        chk("held_first", first_done, 16);
        chk("held_spacing_value", bad, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("held_drain_idle", busy_s, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment driver. It accepts a 16-bit unsigned binary value on a start strobe and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It presents the result as four packed BCD nibbles, most significant digit at [15:12], ready for the driver's 16-bit `data` input. Values above 9999 raise an overflow flag and are saturated or truncated according to a parameter.

## Interface
- `SATURATE`, default 1; 1: overflow drives `bcd` to 16'h9999; 0: overflow drives `bcd` to the low four decimal digits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bin`  in  16  unsigned binary operand; sampled only on the edge that accepts `start`.
- `start`  in  1  conversion request; level-sampled and accepted only when idle.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; `bcd` and `ovf` are valid and updated in the same cycle.
- `bcd`  out  16  four packed BCD digits; holds the last result until the next `done`.
- `ovf`  out  1  last result exceeded 9999; holds until the next `done`.

## Operation
- FSM has two states: IDLE and CONV.
- IDLE: on a clock edge with `start`=1:
  - capture `bin` into a 16-bit shift register;
  - clear the 20-bit BCD accumulator (5 digits) and the 4-bit step counter;
  - go to CONV.
- CONV: each edge performs one double-dabble step:
  - each of the 5 accumulator digits ≥5 gets +3;
  - then shift {accumulator, binary register} left by 1;
  - increment the counter.
- On the 16th step (counter = 15), return to IDLE and register the outputs on the same edge:
  - `done` is set to 1;
  - `ovf` is set when the ten-thousands digit ≠ 0;
  - `bcd` gets the low 16 accumulator bits, or 16'h9999 if `ovf` and `SATURATE`=1.
- `start` while in CONV is ignored; there is no queueing.
- `bin` changes during CONV do not affect the result.
- Arithmetic: digit correction is a 4-bit compare-and-add. No digit can exceed 9 after a shift, so no carry leaves a digit.
- Reset, whether idle or mid-conversion, forces:
  - state IDLE, counter 0;
  - `busy`=0, `done`=0, `bcd`=16'h0000, `ovf`=0.
  - The partial result is discarded.

## Timing
- `busy` is combinational from the state: it rises in the cycle after the start-accepting edge and stays high exactly 16 cycles.
- Latency: `start` sampled at edge k → `done`=1 in the cycle between edges k+16 and k+17, with `bcd`/`ovf` valid from edge k+16.
- `done` is registered and deasserts at the next edge unless a new conversion completes on that edge, which is impossible within 16 cycles.
- Back-to-back: `start` high in the `done` cycle is accepted, because the state is IDLE. The next `done` comes 16 cycles later, giving 1 result per 17 cycles maximum.
- `bcd` is glitch-free: it only changes on the completion edge, so the downstream driver can sample it at any time.

## Structure
- Shared package `bin2bcd_pkg` holds:
  - `BCD_DIGITS`=4, `ACC_DIGITS`=5, `BIN_W`=16, `STEPS`=16;
  - `BCD_SAT`=16'h9999;
  - state encodings `ST_IDLE`=1'b0, `ST_CONV`=1'b1.
- One sub-module, `bcd_add3`: a 4-bit combinational digit corrector, output = in ≥5 ? in+3 : in. It is instantiated 5 times.

## Test plan
- Reset, then `bin`=16'd0 with `start` pulse → 16 busy cycles, `done` pulse, `bcd`=16'h0000, `ovf`=0.
- `bin`=16'd1234 → `bcd`=16'h1234, `ovf`=0, `done` exactly 16 cycles after the start edge. Also `bin`=16'd9999 → 16'h9999, `ovf`=0.
- `bin`=16'd10000 and `bin`=16'd65535:
  - `SATURATE`=1 → `bcd`=16'h9999, `ovf`=1.
  - `SATURATE`=0 → 16'h0000 and 16'h5535 respectively, `ovf`=1.
- `start` with `bin`=16'd42, then `start` with `bin`=16'd77 pulsed at cycle 5, and `bin` changed mid-run → single `done`, `bcd`=16'h0042.
- Completed conversion holding `bcd`=16'h0042, then a new conversion with `rst` asserted at step 8 → all outputs 0 immediately. After release, idle with `busy`=0 and no `done`.
- `start` held high continuously with `bin`=16'd5 → `done` every 17 cycles, each giving `bcd`=16'h0005.
